multi_step_op_handler: RTL and testbench

- Parametrised sequencer for multi-step motion ops (circular, spline-approximated or segmented linear moves) in the processor.
- Per op, runs a configurable number of sub-steps, each a sqrt-unit/motors-control handshake followed by a position update.
- Over the previous generation it adds: internal step counter with runtime step count; a per-step sqrt-recompute mode; a handshake watchdog; an abort path.
- Sits between the op decoder and the sqrt and motors-control units.

---
 rtl/multi_step_op_handler.sv | 195 +++++++++++++++++++
 tb/tb_multi_step_op_handler.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_step_op_handler.sv
// Multi-step motion op sequencer: runs N sub-steps of a sqrt/motors
// handshake followed by a position update, with a watchdog and an abort path.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   clk_en            : clock enable for every piece of state
//   trigger           : start op (taken in IDLE when sqrt_rdy is high)
//   num_steps         : sub-step count, latched on accept
//   sqrt_every_step   : 1 = sqrt before every step, 0 = first step only
//   abort             : cancel the running op
//   sqrt_done/_rdy    : sqrt unit result valid / ready for trigger
//   motors_done/_rdy  : motors move finished / ready for trigger
//   sqrt_trigger      : sqrt start level
//   motors_trigger    : motors start level
//   update_pos        : one-state pulse committing the current step
//   step_idx          : 0-based index of the current step
//   done, rdy         : idle-or-finished / accepts trigger
//   err, aborted      : sticky watchdog-expired / aborted flags
module multi_step_op_handler #(
    parameter int STEP_W         = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              trigger,
    input  logic [STEP_W-1:0] num_steps,
    input  logic              sqrt_every_step,
    input  logic              abort,
    input  logic              sqrt_done,
    input  logic              sqrt_rdy,
    input  logic              motors_done,
    input  logic              motors_rdy,
    output logic              sqrt_trigger,
    output logic              motors_trigger,
    output logic              update_pos,
    output logic [STEP_W-1:0] step_idx,
    output logic              done,
    output logic              rdy,
    output logic              err,
    output logic              aborted
);

    // A zero timeout still gets a 1-bit counter so the declaration stays legal.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit WD_ON = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] WD_MAX =
        (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG_SQRT,
        S_WAIT_SQRT,
        S_WAIT_MRDY,
        S_TRIG_MOT,
        S_WAIT_MOT,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] n_q, n_d;
    logic              every_q, every_d;
    logic [CW-1:0]     wd_q, wd_d;
    logic              err_q, err_d;
    logic              aborted_q, aborted_d;

    logic busy;
    logic in_wait;
    logic wd_hit;
    logic last_step;

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign in_wait   = (state_q == S_WAIT_SQRT) ||
                       (state_q == S_WAIT_MRDY) ||
                       (state_q == S_WAIT_MOT);
    assign wd_hit    = WD_ON && (wd_q == WD_MAX);
    assign last_step = (step_q == (n_q - 1'b1));

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        n_d       = n_q;
        every_d   = every_q;
        err_d     = err_q;
        aborted_d = aborted_q;

        if (busy && abort) begin
            // Abort beats both the normal exit and the watchdog;
            // step_idx is left alone so the stopping point stays visible.
            state_d   = S_DONE;
            aborted_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (trigger && sqrt_rdy) begin
                        n_d       = num_steps;
                        every_d   = sqrt_every_step;
                        step_d    = '0;
                        err_d     = 1'b0;
                        aborted_d = 1'b0;
                        state_d   = (num_steps == '0) ? S_DONE : S_TRIG_SQRT;
                    end
                end
                S_TRIG_SQRT: begin
                    if (!sqrt_rdy) begin
                        state_d = S_WAIT_SQRT;
                    end
                end
                S_WAIT_SQRT: begin
                    if (sqrt_done && motors_rdy) begin
                        state_d = S_TRIG_MOT;
                    end else if (wd_hit) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
                S_WAIT_MRDY: begin
                    if (motors_rdy) begin
                        state_d = S_TRIG_MOT;
                    end else if (wd_hit) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
                S_TRIG_MOT: begin
                    if (!motors_rdy) begin
                        state_d = S_WAIT_MOT;
                    end
                end
                S_WAIT_MOT: begin
                    if (motors_done) begin
                        state_d = S_UPDATE;
                    end else if (wd_hit) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
                S_UPDATE: begin
                    if (last_step) begin
                        state_d = S_DONE;
                    end else begin
                        step_d  = step_q + 1'b1;
                        state_d = every_q ? S_TRIG_SQRT : S_WAIT_MRDY;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Watchdog restarts on every state change and only runs in wait states.
    always_comb begin
        wd_d = '0;
        if ((state_d == state_q) && in_wait) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            n_q       <= '0;
            every_q   <= 1'b0;
            wd_q      <= '0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else if (clk_en) begin
            state_q   <= state_d;
            step_q    <= step_d;
            n_q       <= n_d;
            every_q   <= every_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
        end
    end

    assign sqrt_trigger   = (state_q == S_TRIG_SQRT);
    assign motors_trigger = (state_q == S_TRIG_MOT);
    assign update_pos     = (state_q == S_UPDATE);
    assign done           = (state_q == S_IDLE) || (state_q == S_DONE);
    assign rdy            = (state_q == S_IDLE);
    assign step_idx       = step_q;
    assign err            = err_q;
    assign aborted        = aborted_q;

endmodule

// File: tb/tb_multi_step_op_handler.sv
// Testbench for multi_step_op_handler: responder models for the sqrt and
// motors units, an update_pos scoreboard and one task per scenario.
module tb_multi_step_op_handler;

    localparam int STEP_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clk_en = 1'b1;
    logic              trigger = 1'b0;
    logic [STEP_W-1:0] num_steps = '0;
    logic              sqrt_every_step = 1'b0;
    logic              abort = 1'b0;
    logic              sqrt_done = 1'b0;
    logic              sqrt_rdy = 1'b1;
    logic              motors_done = 1'b0;
    logic              motors_rdy = 1'b1;
    logic              sqrt_trigger;
    logic              motors_trigger;
    logic              update_pos;
    logic [STEP_W-1:0] step_idx;
    logic              done;
    logic              rdy;
    logic              err;
    logic              aborted;

    multi_step_op_handler #(
        .STEP_W        (STEP_W),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_en         (clk_en),
        .trigger        (trigger),
        .num_steps      (num_steps),
        .sqrt_every_step(sqrt_every_step),
        .abort          (abort),
        .sqrt_done      (sqrt_done),
        .sqrt_rdy       (sqrt_rdy),
        .motors_done    (motors_done),
        .motors_rdy     (motors_rdy),
        .sqrt_trigger   (sqrt_trigger),
        .motors_trigger (motors_trigger),
        .update_pos     (update_pos),
        .step_idx       (step_idx),
        .done           (done),
        .rdy            (rdy),
        .err            (err),
        .aborted        (aborted)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    bit en_div = 1'b0;
    int s_lat = 1;
    int m_lat = 1;
    bit m_hang = 1'b0;
    bit abort_en = 1'b0;
    logic [STEP_W-1:0] abort_step = '0;

    int en_cyc = 0;
    int n_sqrt = 0;
    int n_mot = 0;
    int n_upd = 0;
    int n_done = 0;
    int n_busy = 0;
    int n_nosqrt = 0;
    int t_wm = 0;
    int t_done = 0;

    logic [STEP_W-1:0] exp_q[$];

    // clk_en: always 1, or 1-in-4
    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            c++;
            clk_en = en_div ? ((c % 4) == 0) : 1'b1;
        end
    end

    // sqrt unit model, advancing on enabled cycles only
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            if (reset || !clk_en) continue;
            #1;
            if (sqrt_trigger && sqrt_rdy) begin
                sqrt_rdy  = 1'b0;
                sqrt_done = 1'b0;
                cnt = s_lat;
            end else if (!sqrt_rdy) begin
                if (cnt != 0) cnt--;
                else begin
                    sqrt_done = 1'b1;
                    sqrt_rdy  = 1'b1;
                end
            end
        end
    end

    // motors unit model; optionally hangs, or raises abort with motors_done
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            if (reset || !clk_en) continue;
            #1;
            abort = 1'b0;
            if (motors_trigger && motors_rdy) begin
                motors_rdy  = 1'b0;
                motors_done = 1'b0;
                cnt = m_lat;
            end else if (!motors_rdy && !m_hang) begin
                if (cnt != 0) cnt--;
                else begin
                    motors_done = 1'b1;
                    motors_rdy  = 1'b1;
                    if (abort_en && step_idx == abort_step) abort = 1'b1;
                end
            end
        end
    end

    // Monitor: burst/pulse counting and update_pos scoreboard
    initial begin
        bit ps, pm, pend;
        logic [STEP_W-1:0] e;
        ps = 0; pm = 0; pend = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                ps = 0; pm = 0; pend = 0;
                continue;
            end
            if (!clk_en) continue;
            #1;
            en_cyc++;
            if (sqrt_trigger && !ps) begin
                n_sqrt++;
                pend = 1;
            end
            if (motors_trigger && !pm) begin
                n_mot++;
                if (!pend) n_nosqrt++;
                pend = 0;
            end
            if (!motors_trigger && pm) t_wm = en_cyc;
            if (update_pos) begin
                n_upd++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL upd_unexpected: step_idx=%0d, none expected",
                             step_idx);
                end else begin
                    e = exp_q.pop_front();
                    if (step_idx !== e) begin
                        miscompares++;
                        $display("FAIL upd_step_idx: got %0d want %0d",
                                 step_idx, e);
                    end
                end
            end
            if (done && !rdy) begin
                n_done++;
                t_done = en_cyc;
            end
            if (!rdy) n_busy++;
            ps = sqrt_trigger;
            pm = motors_trigger;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int n, input bit every);
        bit ok;
        ok = 0;
        num_steps = STEP_W'(n);
        sqrt_every_step = every;
        trigger = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (!rdy) begin
                ok = 1;
                break;
            end
        end
        trigger = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL accept_timeout: rdy=%0b want 0", rdy);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL idle_timeout: rdy=%0b want 1", rdy);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_updates: left %0d want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({done, rdy, sqrt_trigger, motors_trigger, update_pos, err, aborted}
            !== 7'b1100000) begin
            miscompares++;
            $display("FAIL reset_outs: got %b want 1100000",
                     {done, rdy, sqrt_trigger, motors_trigger, update_pos,
                      err, aborted});
        end
        vectors++;
        if (step_idx !== '0) begin
            miscompares++;
            $display("FAIL reset_step: got %0d want 0", step_idx);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_steps(input bit every);
        int bs, bm, bu, bd, bn;
        bs = n_sqrt; bm = n_mot; bu = n_upd; bd = n_done; bn = n_nosqrt;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        start_op(3, every);
        wait_idle();
        vectors++;
        if (n_sqrt - bs != (every ? 3 : 1)) begin
            miscompares++;
            $display("FAIL steps_sqrt: got %0d want %0d", n_sqrt - bs,
                     every ? 3 : 1);
        end
        vectors++;
        if (n_mot - bm != 3) begin
            miscompares++;
            $display("FAIL steps_mot: got %0d want 3", n_mot - bm);
        end
        vectors++;
        if (n_upd - bu != 3) begin
            miscompares++;
            $display("FAIL steps_upd: got %0d want 3", n_upd - bu);
        end
        vectors++;
        if (n_done - bd != 1) begin
            miscompares++;
            $display("FAIL steps_done_cyc: got %0d want 1", n_done - bd);
        end
        vectors++;
        if (n_nosqrt - bn != (every ? 0 : 2)) begin
            miscompares++;
            $display("FAIL steps_order: got %0d want %0d", n_nosqrt - bn,
                     every ? 0 : 2);
        end
        vectors++;
        if ({done, rdy} !== 2'b11) begin
            miscompares++;
            $display("FAIL steps_idle: got %b want 11", {done, rdy});
        end
    endtask

    task automatic test_zero_steps();
        int bs, bm, bu, bd, bb;
        bs = n_sqrt; bm = n_mot; bu = n_upd; bd = n_done; bb = n_busy;
        start_op(0, 1'b0);
        wait_idle();
        vectors++;
        if ((n_sqrt - bs) + (n_mot - bm) + (n_upd - bu) != 0) begin
            miscompares++;
            $display("FAIL zero_activity: got %0d want 0",
                     (n_sqrt - bs) + (n_mot - bm) + (n_upd - bu));
        end
        vectors++;
        if (n_done - bd != 1 || n_busy - bb != 1) begin
            miscompares++;
            $display("FAIL zero_done: done %0d busy %0d want 1 1",
                     n_done - bd, n_busy - bb);
        end
    endtask

    task automatic test_timeout();
        int bu;
        bu = n_upd;
        m_hang = 1'b1;
        start_op(1, 1'b0);
        wait_idle();
        vectors++;
        if ({err, aborted} !== 2'b10) begin
            miscompares++;
            $display("FAIL to_flags: got %b want 10", {err, aborted});
        end
        vectors++;
        if (t_done - t_wm != 8) begin
            miscompares++;
            $display("FAIL to_latency: got %0d want 8", t_done - t_wm);
        end
        vectors++;
        if (n_upd - bu != 0) begin
            miscompares++;
            $display("FAIL to_upd: got %0d want 0", n_upd - bu);
        end
        m_hang = 1'b0;
        repeat (5) tick();
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL to_sticky: got %b want 1", err);
        end
        bu = n_upd;
        exp_q.push_back(0);
        start_op(1, 1'b0);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL to_clear: got %b want 0", err);
        end
        wait_idle();
        vectors++;
        if (n_upd - bu != 1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL to_recover: upd %0d err %b want 1 0",
                     n_upd - bu, err);
        end
    endtask

    task automatic test_abort();
        int bu;
        bu = n_upd;
        abort_step = 2;
        abort_en = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(1);
        start_op(5, 1'b0);
        wait_idle();
        abort_en = 1'b0;
        vectors++;
        if ({err, aborted} !== 2'b01) begin
            miscompares++;
            $display("FAIL ab_flags: got %b want 01", {err, aborted});
        end
        vectors++;
        if (step_idx !== 2) begin
            miscompares++;
            $display("FAIL ab_step: got %0d want 2", step_idx);
        end
        vectors++;
        if (n_upd - bu != 2) begin
            miscompares++;
            $display("FAIL ab_upd: got %0d want 2", n_upd - bu);
        end
    endtask

    task automatic test_clk_en(input bit div);
        int bs, bm, bu, bd, bb;
        en_div = div;
        repeat (8) tick();
        bs = n_sqrt; bm = n_mot; bu = n_upd; bd = n_done; bb = n_busy;
        exp_q.push_back(0);
        exp_q.push_back(1);
        start_op(2, 1'b0);
        vectors++;
        if (aborted !== 1'b0) begin
            miscompares++;
            $display("FAIL ce_ab_clear: got %b want 0", aborted);
        end
        wait_idle();
        vectors++;
        if (n_busy - bb != 13) begin
            miscompares++;
            $display("FAIL ce_busy(div=%0b): got %0d want 13", div,
                     n_busy - bb);
        end
        vectors++;
        if (n_sqrt - bs != 1 || n_mot - bm != 2) begin
            miscompares++;
            $display("FAIL ce_bursts(div=%0b): got %0d/%0d want 1/2", div,
                     n_sqrt - bs, n_mot - bm);
        end
        vectors++;
        if (n_upd - bu != 2 || n_done - bd != 1) begin
            miscompares++;
            $display("FAIL ce_pulses(div=%0b): got %0d/%0d want 2/1", div,
                     n_upd - bu, n_done - bd);
        end
        en_div = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        ok = 0;
        s_lat = 5;
        start_op(2, 1'b1);
        for (int i = 0; i < 50; i++) begin
            if (!sqrt_trigger) begin
                ok = 1;
                break;
            end
            tick();
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rm_wait_sqrt: sqrt_trigger=%b want 0", sqrt_trigger);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({done, rdy, sqrt_trigger, motors_trigger, update_pos, err, aborted}
            !== 7'b1100000) begin
            miscompares++;
            $display("FAIL rm_outs: got %b want 1100000",
                     {done, rdy, sqrt_trigger, motors_trigger, update_pos,
                      err, aborted});
        end
        vectors++;
        if (step_idx !== '0) begin
            miscompares++;
            $display("FAIL rm_step: got %0d want 0", step_idx);
        end
        repeat (12) tick();
        s_lat = 1;
        vectors++;
        if (rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL rm_stays_idle: rdy=%b want 1", rdy);
        end
    endtask

    initial begin
        test_reset();
        test_steps(1'b0);
        test_steps(1'b1);
        test_zero_steps();
        test_timeout();
        test_abort();
        test_clk_en(1'b0);
        test_clk_en(1'b1);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
